rv_ifetch: RTL and testbench



---
 rtl/rv_ifetch_pkg.sv | 19 +
 rtl/rv_ifetch_buf.sv | 67 ++++++
 rtl/rv_ifetch.sv | 109 ++++++++++
 tb/tb_rv_ifetch.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ifetch_pkg.sv
// rtl/rv_ifetch_pkg.sv - shared widths, constants and types for the fetch stage
package rv_ifetch_pkg;

  localparam int ILEN = 32;
  localparam int XLEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/rv_ifetch_buf.sv
// rtl/rv_ifetch_buf.sv - circular buffer of fetched {instr, pc} entries
module rv_ifetch_buf
  import rv_ifetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 2)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t head_o
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Flush wins over push and pop: the entry arriving with a flush belongs to the old stream.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = ptr_inc(wr_q);
      if (pop_i)  rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (!flush_i) begin
        assert (!(push_i && cnt_q == CW'(DEPTH)))
          else $error("fetch buffer overflow");
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/rv_ifetch.sv
// rtl/rv_ifetch.sv - instruction fetch: PC, imem read issue, latency buffer, decode handshake
module rv_ifetch
  import rv_ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_en,
  output logic            imem_wea,
  output logic [XLEN-1:0] imem_addr,
  output logic [ILEN-1:0] imem_din,
  input  logic [ILEN-1:0] imem_dout,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam int CW  = $clog2(BUF_DEPTH + 2);
  localparam int CWX = CW + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d, fetch_addr;
  logic            inflight_q, inflight_d;
  logic [CW-1:0]   count;
  logic [CWX-1:0]  credit;
  logic            pop, push, issue;
  fetch_entry_t    head, resp;

  assign pop        = out_valid & out_ready;
  assign fetch_addr = redirect_valid ? (redirect_pc & ~32'h3) : pc_q;
  // Entries held plus the read in flight, less the one leaving now, bound new reads.
  assign credit     = {1'b0, count} + CWX'(inflight_q) - CWX'(pop);
  assign issue      = !rst && (redirect_valid || credit < CWX'(BUF_DEPTH));
  assign push       = inflight_q && !redirect_valid;
  assign resp       = '{instr: imem_dout, pc: inflight_pc_q};

  assign imem_en   = issue;
  assign imem_addr = rst ? RESET_PC : fetch_addr;
  assign imem_wea  = 1'b0;
  assign imem_din  = '0;

  assign out_valid = (count != '0);
  assign out_instr = out_valid ? head.instr : NOP_INSTR;
  assign out_pc    = out_valid ? head.pc : '0;

  always_comb begin
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    if (issue) begin
      pc_d          = fetch_addr + 32'd4;
      inflight_pc_d = fetch_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET: state_d = ST_RUN;
      ST_RUN:   if (!issue) state_d = ST_STALL;
      ST_STALL: if (pop || redirect_valid) state_d = ST_RUN;
      default:  state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
      // A stalled fetch with nothing leaving has a full buffer and must not read.
      if (state_q == ST_STALL && !pop && !redirect_valid) begin
        assert (!issue) else $error("fetch issued without credit");
      end
    end
  end

  rv_ifetch_buf #(
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (resp),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .count_o     (count),
    .head_o      (head)
  );

endmodule

// File: tb/tb_rv_ifetch.sv
// tb/tb_rv_ifetch.sv - scoreboard bench for rv_ifetch with directed vectors
module tb_rv_ifetch;
  import rv_ifetch_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_en, imem_wea, redirect_valid = 1'b0, out_valid, out_ready = 1'b1;
  logic [31:0] imem_addr, imem_din, imem_dout = '0, redirect_pc = '0, out_instr, out_pc;

  logic        rst5 = 1'b1;
  logic        imem_en5, imem_wea5, redirect_valid5 = 1'b0, out_valid5, out_ready5 = 1'b1;
  logic [31:0] imem_addr5, imem_din5, imem_dout5 = '0, redirect_pc5 = '0, out_instr5, out_pc5;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  exp_t sb5_q[$];
  exp_t mon_e, mon5_e;

  always #5 clk = ~clk;

  rv_ifetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_wea(imem_wea), .imem_addr(imem_addr),
    .imem_din(imem_din), .imem_dout(imem_dout), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  rv_ifetch #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut5 (
    .clk(clk), .rst(rst5), .imem_en(imem_en5), .imem_wea(imem_wea5), .imem_addr(imem_addr5),
    .imem_din(imem_din5), .imem_dout(imem_dout5), .redirect_valid(redirect_valid5),
    .redirect_pc(redirect_pc5), .out_valid(out_valid5), .out_ready(out_ready5),
    .out_instr(out_instr5), .out_pc(out_pc5)
  );

  // Memory word at byte address a holds a+1, i.e. word[i] = i*4+1.
  always @(posedge clk) begin
    if (imem_en)  imem_dout  <= imem_addr + 32'd1;
    if (imem_en5) imem_dout5 <= imem_addr5 + 32'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    sb_q.push_back('{pc: pc, instr: pc + 32'd1});
  endtask

  // Handshakes during reset or a redirect are void and never consume an expectation.
  always @(negedge clk) begin
    if (!rst && !redirect_valid && out_valid && out_ready) begin
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("sb_pc", out_pc, mon_e.pc);
        check("sb_instr", out_instr, mon_e.instr);
      end else begin
        n_vec++;
        n_err++;
        $display("FAIL sb_extra: unexpected pc %h instr %h", out_pc, out_instr);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst5 && out_valid5 && out_ready5) begin
      if (sb5_q.size() > 0) begin
        mon5_e = sb5_q.pop_front();
        check("wrap_pc", out_pc5, mon5_e.pc);
        check("wrap_instr", out_instr5, mon5_e.instr);
      end else begin
        n_vec++;
        n_err++;
        $display("FAIL wrap_extra: unexpected pc %h", out_pc5);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Ends with rst just released: the caller is in cycle 0, inputs settled.
  task automatic start_phase();
    tick();
    check("sb_drain", sb_q.size(), 0);
    rst = 1'b1;
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_instr", out_instr, NOP_INSTR);
    check("rst_pc", out_pc, 0);
    check("rst_en", imem_en, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_wea", imem_wea, 0);
    check("rst_din", imem_din, 0);
    sb_q.delete();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    // Startup latency, full-rate stream, and the wrap-around instance alongside.
    start_phase();
    rst5 = 1'b0;
    for (int i = 0; i < 5; i++) expect_pc(32'(i * 4));
    sb5_q.push_back('{pc: 32'hFFFF_FFF8, instr: 32'hFFFF_FFF9});
    sb5_q.push_back('{pc: 32'hFFFF_FFFC, instr: 32'hFFFF_FFFD});
    sb5_q.push_back('{pc: 32'h0000_0000, instr: 32'h0000_0001});
    sb5_q.push_back('{pc: 32'h0000_0004, instr: 32'h0000_0005});
    settle();
    check("t1_c0_en", imem_en, 1);
    check("t1_c0_addr", imem_addr, 32'h0);
    check("t1_c0_valid", out_valid, 0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      settle();
      check("t1_en", imem_en, 1);
      check("t1_addr", imem_addr, 32'(c * 4));
      if (c == 1) check("t1_c1_valid", out_valid, 0);
      if (c == 2) check("t1_c2_valid", out_valid, 1);
      if (c == 6) rst5 = 1'b1;
    end
    check("wrap_drain", sb5_q.size(), 0);
    check("wrap_wea", imem_wea5, 0);
    check("wrap_din", imem_din5, 0);

    // Decode stalls from the first valid for five cycles.
    start_phase();
    for (int i = 0; i < 5; i++) expect_pc(32'(i * 4));
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 2) out_ready = 1'b0;
      if (c == 7) out_ready = 1'b1;
      settle();
      if (c >= 2 && c <= 6) begin
        check("t2_hold_valid", out_valid, 1);
        check("t2_hold_pc", out_pc, 32'h0);
        check("t2_hold_en", imem_en, 0);
      end
      if (c == 7) begin
        check("t2_resume_en", imem_en, 1);
        check("t2_resume_addr", imem_addr, 32'h8);
      end
    end

    // Redirect while the buffer is full; the misaligned low bits are dropped.
    start_phase();
    out_ready = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      redirect_valid = 1'b0;
      if (c == 10) begin
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        out_ready = 1'b1;
        sb_q.delete();
        for (int i = 0; i < 4; i++) expect_pc(32'h100 + 32'(i * 4));
      end
      settle();
      if (c == 10) begin
        check("t3_full_pc", out_pc, 32'h4 - 32'h4);
        check("t3_addr", imem_addr, 32'h100);
        check("t3_en", imem_en, 1);
      end
      if (c == 11) check("t3_c11_valid", out_valid, 0);
      if (c == 12) begin
        check("t3_c12_valid", out_valid, 1);
        check("t3_c12_pc", out_pc, 32'h100);
      end
    end

    // Back-to-back redirects: only the second target survives.
    start_phase();
    expect_pc(32'h0);
    expect_pc(32'h4);
    for (int c = 1; c <= 10; c++) begin
      tick();
      redirect_valid = 1'b0;
      if (c == 4 || c == 5) begin
        redirect_valid = 1'b1;
        redirect_pc = (c == 4) ? 32'h40 : 32'h80;
        sb_q.delete();
      end
      if (c == 5) for (int i = 0; i < 4; i++) expect_pc(32'h80 + 32'(i * 4));
      settle();
      if (c == 4) check("t4_addr40", imem_addr, 32'h40);
      if (c == 5) check("t4_addr80", imem_addr, 32'h80);
      if (c == 6) check("t4_c6_valid", out_valid, 0);
      if (c == 7) begin
        check("t4_c7_valid", out_valid, 1);
        check("t4_c7_pc", out_pc, 32'h80);
      end
    end

    // One-cycle reset with two entries buffered.
    start_phase();
    out_ready = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 4) rst = 1'b1;
      if (c == 5) begin
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) expect_pc(32'(i * 4));
      end
      settle();
      if (c == 4) begin
        check("t6_rst_en", imem_en, 0);
        check("t6_rst_addr", imem_addr, 32'h0);
      end
      if (c == 5) begin
        check("t6_valid", out_valid, 0);
        check("t6_instr", out_instr, NOP_INSTR);
        check("t6_pc", out_pc, 32'h0);
        check("t6_addr", imem_addr, 32'h0);
        check("t6_en", imem_en, 1);
      end
      if (c == 7) begin
        check("t6_c7_valid", out_valid, 1);
        check("t6_c7_pc", out_pc, 32'h0);
      end
    end
    tick();
    check("sb_drain", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
